// File: rtl/tile_pack4_tx.sv
// Packs signed Q8.8 scalars into 4-lane tiles with lane mask and last marker; optional clamp via TILE_PACK_CLAMP_EN.
// Latency: the completing beat accepted at cycle N presents its tile at N+1; sustained 1 scalar/cycle, no bubble between tiles.
// Backpressure: the non-completing beats keep flowing while a tile is held; only the completing beat waits for out_ready.
module tile_pack4_tx #(
   parameter int TILE_SIZE = 4,
   parameter int IN_W      = 16,
   parameter int LEN_W     = 16
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            start,
   input  logic [LEN_W-1:0]                cfg_len,
   output logic                            busy,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [IN_W-1:0]                 in_data,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [TILE_SIZE-1:0][IN_W-1:0]  out_vec,
   output logic [TILE_SIZE-1:0]            out_mask,
   output logic                            out_last
);

   localparam int LANE_W = $clog2(TILE_SIZE);

   generate
      if (TILE_SIZE != 4) begin : g_bad_tile
         $error("tile_pack4_tx: only TILE_SIZE=4 is supported");
      end
   endgenerate

   typedef enum logic {
      IDLE = 1'b0,
      FILL = 1'b1
   } state_t;

   state_t                         state;
   logic [LEN_W-1:0]               remaining;
   logic [LANE_W-1:0]              lane_idx;
   logic [TILE_SIZE-1:0][IN_W-1:0] fill_vec;
   logic [TILE_SIZE-1:0]           fill_mask;

   logic                           completing;
   logic                           out_writable;
   logic                           accept;
   logic [IN_W-1:0]                beat_dat;
   logic [TILE_SIZE-1:0][IN_W-1:0] next_vec;
   logic [TILE_SIZE-1:0]           next_mask;

   // A beat closes the tile when it fills the top lane or is the frame's final element.
   assign completing   = (lane_idx == LANE_W'(TILE_SIZE - 1)) || (remaining == LEN_W'(1));
   assign out_writable = !out_valid || out_ready;
   assign in_ready     = (state == FILL) && (!completing || out_writable);
   assign accept       = in_valid && in_ready;
   assign busy         = (state != IDLE) || out_valid;

`ifdef TILE_PACK_CLAMP_EN
   localparam logic signed [IN_W-1:0] SAT_HI = IN_W'(1023);
   localparam logic signed [IN_W-1:0] SAT_LO = IN_W'(-1024);

   // Saturate the incoming scalar into the sigmoid LUT domain before it is stored.
   always_comb begin
      beat_dat = in_data;
      if ($signed(in_data) > SAT_HI) begin
         beat_dat = SAT_HI;
      end else if ($signed(in_data) < SAT_LO) begin
         beat_dat = SAT_LO;
      end
   end
`else
   assign beat_dat = in_data;
`endif

   // Fill lanes with the current beat merged in; lanes above lane_idx are still zero.
   always_comb begin
      next_vec            = fill_vec;
      next_mask           = fill_mask;
      next_vec[lane_idx]  = beat_dat;
      next_mask[lane_idx] = 1'b1;
   end

   // Frame FSM: latch the length on start, walk the lanes, return to IDLE after the final element.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         remaining <= '0;
         lane_idx  <= '0;
         fill_vec  <= '0;
         fill_mask <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start && (cfg_len != '0)) begin
                  remaining <= cfg_len;
                  lane_idx  <= '0;
                  fill_vec  <= '0;
                  fill_mask <= '0;
                  state     <= FILL;
               end
            end
            FILL: begin
               if (accept) begin
                  remaining <= remaining - LEN_W'(1);
                  if (completing) begin
                     lane_idx  <= '0;
                     fill_vec  <= '0;
                     fill_mask <= '0;
                     if (remaining == LEN_W'(1)) begin
                        state <= IDLE;
                     end
                  end else begin
                     lane_idx  <= lane_idx + LANE_W'(1);
                     fill_vec  <= next_vec;
                     fill_mask <= next_mask;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Output register: load on a completing beat, drop valid when consumed, hold contents otherwise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_vec   <= '0;
         out_mask  <= '0;
         out_last  <= 1'b0;
      end else if (accept && completing) begin
         out_valid <= 1'b1;
         out_vec   <= next_vec;
         out_mask  <= next_mask;
         out_last  <= (remaining == LEN_W'(1));
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_tile_pack4_tx.sv
// Self-checking bench for tile_pack4_tx: directed scenarios plus randomized frames against a tile-list model.
// Latency: inputs change 1 ns after each rising edge, outputs are sampled 2 ns after it.
// Backpressure: out_ready is driven directly, randomly toggled in the randomized frames.
module tb_tile_pack4_tx;

   logic             clk;
   logic             rst;
   logic             start;
   logic [15:0]      cfg_len;
   logic             busy;
   logic             in_valid;
   logic             in_ready;
   logic [15:0]      in_data;
   logic             out_valid;
   logic             out_ready;
   logic [3:0][15:0] out_vec;
   logic [3:0]       out_mask;
   logic             out_last;

   typedef struct packed {
      logic [63:0] vec;
      logic [3:0]  mask;
      logic        last;
   } tile_t;

   tile_t       expq[$];
   logic [15:0] frame_dat [0:63];
   int          total;
   int          bad;
   logic        acc;

   tile_pack4_tx #(.TILE_SIZE(4), .IN_W(16), .LEN_W(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .cfg_len   (cfg_len),
      .busy      (busy),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_vec   (out_vec),
      .out_mask  (out_mask),
      .out_last  (out_last)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference value of one stored scalar: optional saturation to [-1024, 1023].
   function automatic logic [15:0] model_val(input logic [15:0] x);
      int v;
      v = int'($signed(x));
`ifdef TILE_PACK_CLAMP_EN
      if (v > 1023) v = 1023;
      if (v < -1024) v = -1024;
`endif
      return 16'(v);
   endfunction

   // A frame of n elements is cut into groups of four; the tail group is zero padded.
   task automatic push_frame(input int n);
      for (int b = 0; b < n; b += 4) begin
         tile_t t;
         t = '0;
         for (int l = 0; l < 4; l++) begin
            if (b + l < n) begin
               t.vec[l*16 +: 16] = model_val(frame_dat[b+l]);
               t.mask[l]         = 1'b1;
            end
         end
         t.last = (b + 4 >= n);
         expq.push_back(t);
      end
   endtask

   // One clock cycle: drive, observe handshakes, score any tile that fires, advance.
   task automatic cyc(input logic st, input logic [15:0] len, input logic iv,
                      input logic [15:0] id, input logic ordy);
      tile_t t;
      start     = st;
      cfg_len   = len;
      in_valid  = iv;
      in_data   = id;
      out_ready = ordy;
      #1;
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
         chk("fire_expected", 64'(expq.size() != 0), 64'd1);
         if (expq.size() != 0) begin
            t = expq.pop_front();
            chk("tile_vec", out_vec, t.vec);
            chk("tile_mask", 64'(out_mask), 64'(t.mask));
            chk("tile_last", 64'(out_last), 64'(t.last));
         end
      end
      @(posedge clk);
      #1;
      start    = 1'b0;
      in_valid = 1'b0;
   endtask

   task automatic run_frame(input int n, input int pv, input int pr);
      int idx;
      int cnt;
      idx = 0;
      cnt = 0;
      while (idx < n && cnt < 2000) begin
         cyc(1'b0, 16'd0, 1'($urandom_range(99) < pv), frame_dat[idx],
             1'($urandom_range(99) < pr));
         if (acc) idx++;
         cnt++;
      end
      chk("frame_beats", 64'(idx), 64'(n));
   endtask

   task automatic drain();
      int cnt;
      cnt = 0;
      while (expq.size() != 0 && cnt < 100) begin
         cyc(1'b0, 16'd0, 1'b0, 16'd0, 1'b1);
         cnt++;
      end
      chk("drain_empty", 64'(expq.size()), 64'd0);
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      acc       = 1'b0;
      rst       = 1'b1;
      start     = 1'b0;
      cfg_len   = '0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_vec", out_vec, 64'd0);
      chk("rst_out_mask", 64'(out_mask), 64'd0);
      chk("rst_out_last", 64'(out_last), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Full 8-element frame at full rate: tiles one cycle after beats 4 and 8.
      for (int i = 0; i < 8; i++) frame_dat[i] = 16'((i + 1) * 256);
      push_frame(8);
      cyc(1'b1, 16'd8, 1'b0, 16'd0, 1'b1);
      for (int i = 0; i < 8; i++) begin
         chk("t1_out_valid", 64'(out_valid), 64'(i == 4));
         chk("t1_in_ready", 64'(in_ready), 64'd1);
         cyc(1'b0, 16'd0, 1'b1, frame_dat[i], 1'b1);
      end
      chk("t1_tail_valid", 64'(out_valid), 64'd1);
      chk("t1_tail_busy", 64'(busy), 64'd1);
      cyc(1'b0, 16'd0, 1'b0, 16'd0, 1'b1);
      chk("t1_busy_drop", 64'(busy), 64'd0);
      chk("t1_valid_drop", 64'(out_valid), 64'd0);

      // Six elements: tail tile carries two lanes.
      for (int i = 0; i < 6; i++) frame_dat[i] = 16'(i + 1);
      push_frame(6);
      cyc(1'b1, 16'd6, 1'b0, 16'd0, 1'b1);
      run_frame(6, 100, 100);
      drain();

      // Backpressure: only the completing 8th beat waits for the held tile.
      for (int i = 0; i < 8; i++) frame_dat[i] = 16'((i + 1) * 16);
      push_frame(8);
      cyc(1'b1, 16'd8, 1'b0, 16'd0, 1'b0);
      for (int i = 0; i < 4; i++) cyc(1'b0, 16'd0, 1'b1, frame_dat[i], 1'b0);
      for (int i = 4; i < 7; i++) begin
         chk("t3_held_valid", 64'(out_valid), 64'd1);
         chk("t3_held_vec", out_vec, expq[0].vec);
         cyc(1'b0, 16'd0, 1'b1, frame_dat[i], 1'b0);
         chk("t3_beat_acc", 64'(acc), 64'd1);
      end
      for (int i = 0; i < 2; i++) begin
         cyc(1'b0, 16'd0, 1'b1, frame_dat[7], 1'b0);
         chk("t3_last_stall", 64'(acc), 64'd0);
         chk("t3_held_mask", 64'(out_mask), 64'(expq[0].mask));
      end
      cyc(1'b0, 16'd0, 1'b1, frame_dat[7], 1'b1);
      chk("t3_last_acc", 64'(acc), 64'd1);
      chk("t3_tile2_valid", 64'(out_valid), 64'd1);
      drain();

      // Start while filling is ignored (its length would restart the lanes).
      for (int i = 0; i < 4; i++) frame_dat[i] = 16'(16'h0A00 + i);
      push_frame(4);
      cyc(1'b1, 16'd4, 1'b0, 16'd0, 1'b1);
      run_frame(2, 100, 100);
      cyc(1'b1, 16'd7, 1'b0, 16'd0, 1'b1);
      for (int i = 2; i < 4; i++) cyc(1'b0, 16'd0, 1'b1, frame_dat[i], 1'b1);
      drain();
      chk("t4_idle_busy", 64'(busy), 64'd0);

      // Reset mid-frame discards the partial tile.
      cyc(1'b1, 16'd4, 1'b0, 16'd0, 1'b1);
      cyc(1'b0, 16'd0, 1'b1, 16'h1111, 1'b1);
      cyc(1'b0, 16'd0, 1'b1, 16'h2222, 1'b1);
      rst = 1'b1;
      #1;
      chk("t4_rst_valid", 64'(out_valid), 64'd0);
      chk("t4_rst_busy", 64'(busy), 64'd0);
      chk("t4_rst_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) frame_dat[i] = 16'(16'h0300 + i * 3);
      push_frame(4);
      cyc(1'b1, 16'd4, 1'b0, 16'd0, 1'b1);
      run_frame(4, 100, 100);
      drain();

      // Zero-length start is ignored.
      cyc(1'b1, 16'd0, 1'b1, 16'h0055, 1'b1);
      for (int i = 0; i < 3; i++) begin
         chk("t5_in_ready", 64'(in_ready), 64'd0);
         chk("t5_busy", 64'(busy), 64'd0);
         chk("t5_out_valid", 64'(out_valid), 64'd0);
         cyc(1'b0, 16'd0, 1'b1, 16'h0055, 1'b1);
      end

      // Clamp boundary values.
      frame_dat[0] = 16'h7000;
      frame_dat[1] = 16'h8000;
      frame_dat[2] = 16'h0200;
      frame_dat[3] = 16'hFC00;
      push_frame(4);
      cyc(1'b1, 16'd4, 1'b0, 16'd0, 1'b0);
      run_frame(4, 100, 0);
`ifdef TILE_PACK_CLAMP_EN
      chk("t6_clamp_vec", out_vec, 64'hFC00_0200_FC00_03FF);
`else
      chk("t6_clamp_vec", out_vec, 64'hFC00_0200_8000_7000);
`endif
      drain();

      // Randomized frames, back-to-back starts while a tail tile may still be held.
      for (int f = 0; f < 8; f++) begin
         int n;
         n = int'($urandom_range(13, 1));
         for (int i = 0; i < n; i++) frame_dat[i] = 16'($urandom);
         push_frame(n);
         cyc(1'b1, 16'(n), 1'b0, 16'd0, 1'($urandom_range(1)));
         run_frame(n, 70, 60);
      end
      drain();
      chk("rand_end_busy", 64'(busy), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
